mu0_pcstack: RTL and testbench
==============================

Name: mu0_pcstack

Overview:
- Parametrised successor to the MU0 12-bit enabled register; serves as the program-counter register of the extended MU0 datapath.
- Adds increment, decrement and clear modes, a carry/borrow flag, and a DEPTH-entry LIFO of return addresses for JSR/RTS-style call and return.
- Sits between the instruction decoder (drives En/Op) and the address mux (consumes Q).

Parameters:
WIDTH, 12, register and stack entry width in bits (>=2)
DEPTH, 4, return-address stack entries (>=2)
RESET_VAL, 0, value loaded into Q on reset (WIDTH bits)

Ports:
Clk  input  1  clock; all state changes on rising edge
nReset  input  1  asynchronous, active-low reset
En  input  1  operation enable; 0 = no state change regardless of Op
Op  input  3  operation select (encoding below)
D  input  WIDTH  load / jump target
Q  output  WIDTH  current register value (registered)
Carry  output  1  carry/borrow from last INC/DEC (registered)
Full  output  1  stack holds DEPTH entries
Empty  output  1  stack holds 0 entries
Err  output  1  sticky stack overflow/underflow flag (registered)

Behaviour:
- One clock, Clk. Reset is asynchronous and active-low: nReset=0 forces Q=RESET_VAL, Carry=0, Err=0, stack count=0 immediately, independent of Clk. Stack contents are don't-care after reset.
- Reset mid-operation discards any in-progress stack contents; the first edge after release executes normally.
- Full and Empty are combinational decodes of the registered count: Full=(count==DEPTH), Empty=(count==0). After reset Empty=1, Full=0.
- Count is ceil(log2(DEPTH+1)) bits.
- En=0: Q, Carry, Err, count and stack are held for any Op.
- En=1, on rising Clk, Op encoding:
  - 000 HOLD: no change.
  - 001 LOAD: Q<=D; Carry<=0.
  - 010 INC: Q<=Q+1, wrapping modulo 2^WIDTH; Carry<=(Q==all ones).
  - 011 DEC: Q<=Q-1, wrapping; Carry<=(Q==0).
  - 100 PUSH (call): if !Full: stack[count]<=Q+1 (wrapped), count<=count+1, Q<=D, Carry<=0. If Full: no change to Q, stack, count or Carry; Err<=1.
  - 101 POP (return): if !Empty: Q<=stack[count-1], count<=count-1, Carry<=0. If Empty: no change to Q, count or Carry; Err<=1.
  - 110 CLR: Q<=0; Carry<=0; stack untouched.
  - 111 FLUSH: count<=0; Err<=0; Q and Carry unchanged.
- Latency: every result is visible on Q/Carry/Err one cycle after the enabling edge. Full/Empty update in the same cycle as count.
- Err is sticky: it clears only on FLUSH or reset. It never blocks subsequent operations.
- PUSH when Q is all ones stores 0 (wrapped return address) and does not set Carry.
- Back-to-back PUSH/POP on consecutive cycles must work without bubbles. POP immediately after PUSH returns the just-pushed value.

Test Plan:
- Reset: drive nReset=0 asynchronously mid-cycle with Q=0x123 -> Q=0x000, Empty=1, Full=0, Err=0, Carry=0 before the next Clk edge.
- Modes: LOAD 0xFFE, INC, INC -> Q=0xFFF (Carry=0), then Q=0x000 (Carry=1); DEC -> Q=0xFFF, Carry=1; CLR -> Q=0, Carry=0; En=0 with Op=LOAD D=0x555 -> Q unchanged.
- Call/return: Q=0x010; PUSH D=0x200 -> Q=0x200, count 1; PUSH D=0x300 -> Q=0x300; POP -> Q=0x201; POP -> Q=0x011, Empty=1.
- Overflow: four PUSHes fill the stack (Full=1); fifth PUSH D=0xABC -> Q unchanged, Err=1, count stays 4; POP returns the 4th entry; Err stays 1 until FLUSH -> Err=0, Empty=1.
- Underflow: from Empty, POP -> Q unchanged, Err=1, Empty still 1.
- Wrap on push: Q=0xFFF; PUSH D=0x100 then POP -> Q=0x000, Carry=0.

Source files
------------

// File: rtl/mu0_pcstack.sv
// MU0 program-counter register with load/inc/dec/clear modes, carry flag and a
// small return-address stack for call/return.
module mu0_pcstack #(
  parameter int unsigned      WIDTH     = 12,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             En,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Carry,
  output logic             Full,
  output logic             Empty,
  output logic             Err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OpHold  = 3'b000,
    OpLoad  = 3'b001,
    OpInc   = 3'b010,
    OpDec   = 3'b011,
    OpPush  = 3'b100,
    OpPop   = 3'b101,
    OpClr   = 3'b110,
    OpFlush = 3'b111
  } op_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [WIDTH-1:0] q_inc;
  logic [CW-1:0]    count_dec;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             push_we;
  logic             full, empty;

  assign q_inc     = q_q + WIDTH'(1);
  assign count_dec = count_q - CW'(1);
  assign wr_idx    = count_q[AW-1:0];
  assign rd_idx    = count_dec[AW-1:0];
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    err_d   = err_q;
    count_d = count_q;
    push_we = 1'b0;
    if (En) begin
      unique case (op_e'(Op))
        OpHold: ;
        OpLoad: begin
          q_d     = D;
          carry_d = 1'b0;
        end
        OpInc: begin
          q_d     = q_inc;
          carry_d = (q_q == '1);
        end
        OpDec: begin
          q_d     = q_q - WIDTH'(1);
          carry_d = (q_q == '0);
        end
        OpPush: begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            push_we = 1'b1;
            count_d = count_q + CW'(1);
            q_d     = D;
            carry_d = 1'b0;
          end
        end
        OpPop: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            q_d     = stack_q[rd_idx];
            count_d = count_dec;
            carry_d = 1'b0;
          end
        end
        OpClr: begin
          q_d     = '0;
          carry_d = 1'b0;
        end
        OpFlush: begin
          count_d = '0;
          err_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      q_q     <= RESET_VAL;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Stack contents need no reset; the count alone defines what is valid.
  always_ff @(posedge Clk) begin
    if (push_we) begin
      stack_q[wr_idx] <= q_inc;
    end
  end

  assign Q     = q_q;
  assign Carry = carry_q;
  assign Err   = err_q;
  assign Full  = full;
  assign Empty = empty;

endmodule

// File: tb/tb_mu0_pcstack.sv
// Self-checking bench for mu0_pcstack: reference model feeds an expected-value
// queue that is drained and compared after each clock edge.
module tb_mu0_pcstack;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned DEPTH = 4;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, INC = 3'b010, DEC = 3'b011;
  localparam logic [2:0] PUSH = 3'b100, POP = 3'b101, CLR = 3'b110, FLUSH = 3'b111;

  logic             Clk = 1'b0;
  logic             nReset;
  logic             En;
  logic [2:0]       Op;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             Carry, Full, Empty, Err;

  mu0_pcstack #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VAL(12'h000)
  ) dut (
    .Clk   (Clk),
    .nReset(nReset),
    .En    (En),
    .Op    (Op),
    .D     (D),
    .Q     (Q),
    .Carry (Carry),
    .Full  (Full),
    .Empty (Empty),
    .Err   (Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             full;
    logic             empty;
    logic             err;
  } exp_t;

  exp_t sb[$];

  logic [WIDTH-1:0] m_q;
  logic             m_c;
  logic             m_err;
  logic [WIDTH-1:0] m_stk[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q   = '0;
    m_c   = 1'b0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".q"}, 32'(Q), 32'(m_q));
    check({tag, ".carry"}, 32'(Carry), 32'(m_c));
    check({tag, ".empty"}, 32'(Empty), 32'(m_stk.size() == 0));
    check({tag, ".full"}, 32'(Full), 32'(m_stk.size() == DEPTH));
    check({tag, ".err"}, 32'(Err), 32'(m_err));
  endtask

  task automatic do_op(input string tag, input logic en, input logic [2:0] op,
                       input logic [WIDTH-1:0] d);
    exp_t e;
    @(negedge Clk);
    En = en;
    Op = op;
    D  = d;
    if (en) begin
      case (op)
        LOAD: begin m_q = d; m_c = 1'b0; end
        INC:  begin m_c = (m_q == 12'hFFF); m_q = m_q + 12'h001; end
        DEC:  begin m_c = (m_q == 12'h000); m_q = m_q - 12'h001; end
        PUSH: begin
          if (m_stk.size() == DEPTH) m_err = 1'b1;
          else begin
            m_stk.push_back(m_q + 12'h001);
            m_q = d;
            m_c = 1'b0;
          end
        end
        POP: begin
          if (m_stk.size() == 0) m_err = 1'b1;
          else begin
            m_q = m_stk.pop_back();
            m_c = 1'b0;
          end
        end
        CLR:   begin m_q = '0; m_c = 1'b0; end
        FLUSH: begin m_stk.delete(); m_err = 1'b0; end
        default: ;
      endcase
    end
    e.q     = m_q;
    e.carry = m_c;
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".q"}, 32'(Q), 32'(e.q));
      check({tag, ".carry"}, 32'(Carry), 32'(e.carry));
      check({tag, ".full"}, 32'(Full), 32'(e.full));
      check({tag, ".empty"}, 32'(Empty), 32'(e.empty));
      check({tag, ".err"}, 32'(Err), 32'(e.err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nReset = 1'b0;
    En     = 1'b0;
    Op     = HOLD;
    D      = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_state("por");
    check("por.empty_k", 32'(Empty), 32'd1);
    @(negedge Clk);
    nReset = 1'b1;

    // Asynchronous reset mid-cycle with a live value and a stacked entry
    do_op("ld123", 1'b1, LOAD, 12'h123);
    do_op("pushr", 1'b1, PUSH, 12'h123);
    @(posedge Clk);
    #2;
    nReset = 1'b0;
    #1;
    model_reset();
    check("arst.q", 32'(Q), 32'h000);
    check("arst.empty", 32'(Empty), 32'd1);
    check("arst.full", 32'(Full), 32'd0);
    check("arst.err", 32'(Err), 32'd0);
    check("arst.carry", 32'(Carry), 32'd0);
    En = 1'b0;
    @(negedge Clk);
    nReset = 1'b1;

    // Modes
    do_op("ldffe", 1'b1, LOAD, 12'hFFE);
    do_op("inc1", 1'b1, INC, 12'h000);
    check("inc1.k", 32'(Q), 32'hFFF);
    do_op("inc2", 1'b1, INC, 12'h000);
    check("inc2.kq", 32'(Q), 32'h000);
    check("inc2.kc", 32'(Carry), 32'd1);
    do_op("dec", 1'b1, DEC, 12'h000);
    check("dec.kq", 32'(Q), 32'hFFF);
    check("dec.kc", 32'(Carry), 32'd1);
    do_op("clr", 1'b1, CLR, 12'h000);
    check("clr.kq", 32'(Q), 32'h000);
    do_op("en0", 1'b0, LOAD, 12'h555);
    check("en0.kq", 32'(Q), 32'h000);
    do_op("hold", 1'b1, HOLD, 12'h777);

    // Call / return
    do_op("ld010", 1'b1, LOAD, 12'h010);
    do_op("call1", 1'b1, PUSH, 12'h200);
    do_op("call2", 1'b1, PUSH, 12'h300);
    do_op("ret2", 1'b1, POP, 12'h000);
    check("ret2.kq", 32'(Q), 32'h201);
    do_op("ret1", 1'b1, POP, 12'h000);
    check("ret1.kq", 32'(Q), 32'h011);
    check("ret1.kempty", 32'(Empty), 32'd1);

    // Overflow
    for (int i = 1; i <= 4; i++) do_op("fill", 1'b1, PUSH, 12'(i * 256));
    check("fill.kfull", 32'(Full), 32'd1);
    do_op("ovf", 1'b1, PUSH, 12'hABC);
    check("ovf.kq", 32'(Q), 32'h400);
    check("ovf.kerr", 32'(Err), 32'd1);
    do_op("ovfpop", 1'b1, POP, 12'h000);
    check("ovfpop.kq", 32'(Q), 32'h301);
    check("ovfpop.kerr", 32'(Err), 32'd1);
    do_op("sticky", 1'b1, LOAD, 12'h044);
    do_op("flush", 1'b1, FLUSH, 12'h000);
    check("flush.kerr", 32'(Err), 32'd0);
    check("flush.kempty", 32'(Empty), 32'd1);

    // Underflow
    do_op("udf", 1'b1, POP, 12'h000);
    check("udf.kq", 32'(Q), 32'h044);
    check("udf.kerr", 32'(Err), 32'd1);
    do_op("flush2", 1'b1, FLUSH, 12'h000);

    // Return address wrap; push also clears a set carry
    do_op("ldfff", 1'b1, LOAD, 12'hFFF);
    do_op("incw", 1'b1, INC, 12'h000);
    do_op("decw", 1'b1, DEC, 12'h000);
    do_op("pushw", 1'b1, PUSH, 12'h100);
    check("pushw.kc", 32'(Carry), 32'd0);
    do_op("popw", 1'b1, POP, 12'h000);
    check("popw.kq", 32'(Q), 32'h000);
    check("popw.kc", 32'(Carry), 32'd0);

    // Back-to-back random traffic biased toward stack ops
    for (int i = 0; i < 200; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) op = {2'b10, 1'($urandom_range(0, 1))};
      do_op("rnd", 1'($urandom_range(0, 5) != 0), op, 12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
